// File: rtl/seq_divider_8x4_if.sv
// Handshake and operand/result bundle for seq_divider_8x4.
interface seq_divider_8x4_if;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/seq_divider_8x4.sv
// Sequential restoring divider: 8-bit dividend / 4-bit divisor,
// one quotient bit per clock under a start/done handshake.
module seq_divider_8x4 (
  input logic                clk,
  input logic                rst_n,
  seq_divider_8x4_if.slave   bus
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t     r_state;
  state_t     w_next;
  // Dividend shifts out of the MSB while quotient bits shift into the LSB.
  logic [7:0] r_dq;
  logic [3:0] r_dvs;
  // Restored partial remainder is always < divisor, so 4 bits hold it;
  // the 5-bit trial value exists only combinationally.
  logic [3:0] r_pr;
  logic [2:0] r_cnt;
  logic [7:0] r_quotient;
  logic [3:0] r_remainder;
  logic       r_done;
  logic       r_dbz;

  logic [4:0] w_pr_shift;
  logic       w_qbit;
  logic [3:0] w_pr_next;
  logic [7:0] w_dq_next;
  logic       w_accept;

  assign w_pr_shift = {r_pr, r_dq[7]};
  assign w_qbit     = (w_pr_shift >= {1'b0, r_dvs});
  // Difference is < 16 whenever it is selected, so 4-bit arithmetic suffices.
  assign w_pr_next  = w_qbit ? (w_pr_shift[3:0] - r_dvs) : w_pr_shift[3:0];
  assign w_dq_next  = {r_dq[6:0], w_qbit};
  assign w_accept   = bus.start && (bus.divisor != 4'd0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RUN;
      S_RUN:   if (r_cnt == 3'd0) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: operand latch, restoring steps and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dq        <= '0;
      r_dvs       <= '0;
      r_pr        <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_done      <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.divisor != 4'd0) begin
              r_dq  <= bus.dividend;
              r_dvs <= bus.divisor;
              r_pr  <= '0;
              r_cnt <= 3'd7;
            end else begin
              r_quotient  <= '1;
              r_remainder <= '0;
              r_dbz       <= 1'b1;
              r_done      <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_pr  <= w_pr_next;
          r_dq  <= w_dq_next;
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd0) begin
            r_quotient  <= w_dq_next;
            r_remainder <= w_pr_next;
            r_dbz       <= 1'b0;
            r_done      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.busy        = (r_state == S_RUN);
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider_8x4.sv
// Self-checking bench for seq_divider_8x4 against an arithmetic reference.
module tb_seq_divider_8x4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  seq_divider_8x4_if u_if ();

  seq_divider_8x4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: plain integer division; divide-by-zero yields all-ones / 0.
  function automatic void ref_div(input int a, input int b, output int q, output int r);
    if (b == 0) begin
      q = 255;
      r = 0;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Issue one request and check the whole response timeline.
  task automatic run_op(input int a, input int b);
    int q, r;
    ref_div(a, b, q, r);
    @(negedge clk);
    u_if.dividend = a[7:0];
    u_if.divisor  = b[3:0];
    u_if.start    = 1'b1;
    @(posedge clk); #1;
    u_if.start = 1'b0;
    if (b == 0) begin
      check("dz_done", u_if.done, 1);
      check("dz_flag", u_if.div_by_zero, 1);
      check("dz_busy", u_if.busy, 0);
      check("dz_quo", u_if.quotient, q);
      check("dz_rem", u_if.remainder, r);
    end else begin
      check("acc_busy", u_if.busy, 1);
      check("acc_done", u_if.done, 0);
      for (int i = 1; i < 8; i++) begin
        @(posedge clk); #1;
        check("run_busy", u_if.busy, 1);
        check("run_done", u_if.done, 0);
      end
      @(posedge clk); #1;
      check("fin_done", u_if.done, 1);
      check("fin_busy", u_if.busy, 0);
      check("fin_quo", u_if.quotient, q);
      check("fin_rem", u_if.remainder, r);
      check("fin_dz", u_if.div_by_zero, 0);
    end
    @(posedge clk); #1;
    check("pulse_end", u_if.done, 0);
    check("hold_quo", u_if.quotient, q);
    check("idle_busy", u_if.busy, 0);
  endtask

  initial begin
    u_if.start    = 1'b0;
    u_if.dividend = '0;
    u_if.divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_quo", u_if.quotient, 0);
    check("rst_rem", u_if.remainder, 0);
    check("rst_busy", u_if.busy, 0);
    check("rst_done", u_if.done, 0);
    check("rst_dz", u_if.div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(200, 13);
    for (int a = 1; a <= 15; a++)
      for (int b = 1; b <= 15; b++)
        run_op(a * b, b);
    run_op(255, 1);
    run_op(0, 7);
    run_op(14, 15);
    run_op(99, 0);
    run_op(99, 9);

    for (int k = 0; k < 40; k++)
      run_op(int'($urandom_range(255, 0)), int'($urandom_range(15, 0)));

    // Start during RUN is ignored; start held in the done cycle is accepted.
    @(negedge clk);
    u_if.dividend = 8'd100;
    u_if.divisor  = 4'd3;
    u_if.start    = 1'b1;
    @(posedge clk); #1;               // edge N
    u_if.start = 1'b0;
    repeat (2) @(posedge clk);        // edges N+1, N+2
    @(negedge clk);
    u_if.dividend = 8'd50;
    u_if.divisor  = 4'd5;
    u_if.start    = 1'b1;
    repeat (6) @(posedge clk);        // edges N+3..N+8
    #1;
    check("b2b_done1", u_if.done, 1);
    check("b2b_quo1", u_if.quotient, 33);
    check("b2b_rem1", u_if.remainder, 1);
    @(posedge clk); #1;               // edge N+9 accepts 50/5
    u_if.start = 1'b0;
    check("b2b_busy2", u_if.busy, 1);
    check("b2b_hold", u_if.quotient, 33);
    repeat (8) @(posedge clk);
    #1;
    check("b2b_done2", u_if.done, 1);
    check("b2b_quo2", u_if.quotient, 10);
    check("b2b_rem2", u_if.remainder, 0);

    // Asynchronous reset in the middle of a RUN.
    @(negedge clk);
    u_if.dividend = 8'd255;
    u_if.divisor  = 4'd7;
    u_if.start    = 1'b1;
    @(posedge clk); #1;
    u_if.start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_quo", u_if.quotient, 0);
    check("arst_rem", u_if.remainder, 0);
    check("arst_busy", u_if.busy, 0);
    check("arst_done", u_if.done, 0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("arst_nodone", u_if.done, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(255, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
